cpu_ctrl: RTL
=============

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port: mem_rdata  input  8  memory read data, valid one cycle after mem_rd with mem_addr.
REQ-004 SHALL have port: acc_zero  input  1  accumulator currently equals 8'h00.
REQ-005 SHALL have port: mem_addr  output  5  memory address.
REQ-006 SHALL have port: mem_rd  output  1  memory read strobe.
REQ-007 SHALL have port: mem_wr  output  1  memory write strobe; write data is the accumulator.
REQ-008 SHALL have port: acc_load  output  1  accumulator load enable.
REQ-009 SHALL have port: acc_sel  output  1  accumulator source: 1 = memory data, 0 = ALU result.
REQ-010 SHALL have port: alu_op  output  3  opcode of the current instruction.
REQ-011 SHALL have port: halt  output  1  processor halted.

Function
REQ-012 SHALL decode the instruction word as opcode = [7:5] and operand address = [4:0].
REQ-013 SHALL support opcodes 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO and 111 JMP.
REQ-014 SHALL run a Moore FSM with states FETCH, DECODE, EXEC, WB and HALT; all outputs are decoded from state and the internal IR.
REQ-015 SHALL in FETCH drive mem_addr = PC and mem_rd = 1, then go to DECODE.
REQ-016 SHALL in DECODE capture mem_rdata into IR and increment PC by 1 (5-bit, 31 wraps to 0), then go to EXEC.
REQ-017 SHALL in EXEC behave as follows, then go to WB:
- ADD, AND, XOR, LDA: drive mem_addr = IR[4:0] and mem_rd = 1.
- STO: drive mem_addr = IR[4:0] and mem_wr = 1 for exactly this one cycle.
- JMP: load PC with IR[4:0].
- SKZ: increment PC by 1 (wrapping) when acc_zero = 1.
REQ-018 SHALL on HLT in EXEC go to HALT instead of WB.
REQ-019 SHALL in WB assert acc_load = 1 for ADD, AND, XOR and LDA, with acc_sel = 1 for LDA and 0 otherwise, then go to FETCH.
REQ-020 SHALL give each non-HLT instruction exactly 4 cycles (FETCH through WB).
REQ-021 SHALL sample acc_zero during EXEC of SKZ; no accumulator write occurs in that instruction.
REQ-022 SHALL hold alu_op = IR[7:5] from DECODE+1 onward.
REQ-023 SHALL keep halt = 1 in HALT with all strobes 0; HALT is left only by reset.
REQ-024 SHALL drive mem_rd, mem_wr and acc_load to 0 in every state not listed above; mem_rd and mem_wr are never both 1.
REQ-025 SHALL on a JMP to the current PC value loop on that instruction indefinitely without error.

Reset
REQ-026 SHALL while rst = 0 immediately force: state FETCH, PC 0, IR 8'h00, mem_rd/mem_wr/acc_load/acc_sel/halt 0, mem_addr 0, alu_op 0.
REQ-027 SHALL abort any in-flight instruction on reset assertion mid-operation, including a STO in EXEC (mem_wr drops asynchronously).
REQ-028 SHALL begin FETCH of address 0 on the first rising edge after rst returns to 1.

Configuration
REQ-029 SHALL compile conditional skip support under the macro CPU_CTRL_SKZ_EN.
REQ-030 SHALL when CPU_CTRL_SKZ_EN is defined implement SKZ as specified in REQ-017.
REQ-031 SHALL when CPU_CTRL_SKZ_EN is undefined execute SKZ as a 4-cycle NOP: PC is not adjusted and acc_zero is ignored.

Verification
REQ-032 SHALL cover: reset release with mem[0] = 8'hA3 (LDA 3), mem[3] = 8'h5C -> acc_load = 1 and acc_sel = 1 at cycle 4, PC = 1.
REQ-033 SHALL cover: program LDA, ADD, STO 5'h1F -> mem_wr = 1 with mem_addr = 5'h1F for exactly one cycle in the 3rd instruction's EXEC.
REQ-034 SHALL cover: SKZ with acc_zero = 1 at PC = 4 -> next FETCH address 6 with macro defined, 5 without.
REQ-035 SHALL cover: JMP 5'h10 at address 31 -> PC wraps to 0 in DECODE, then the next FETCH address is 16.
REQ-036 SHALL cover: HLT -> halt = 1 from cycle 4 and all strobes 0 for 20 further cycles; rst = 0 then clears halt and restarts FETCH at address 0.
REQ-037 SHALL cover: rst = 0 asserted mid-STO in EXEC -> mem_wr falls before the next clock edge, and PC = 0 after reset release.

Source files
------------

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - memory and accumulator control bus between cpu_ctrl and its datapath
interface cpu_ctrl_if;
    logic [7:0] mem_rdata;
    logic       acc_zero;
    logic [4:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_load;
    logic       acc_sel;
    logic [2:0] alu_op;
    logic       halt;

    modport master (
        input  mem_rdata, acc_zero,
        output mem_addr, mem_rd, mem_wr, acc_load, acc_sel, alu_op, halt
    );

    modport slave (
        output mem_rdata, acc_zero,
        input  mem_addr, mem_rd, mem_wr, acc_load, acc_sel, alu_op, halt
    );
endinterface

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - 4-cycle accumulator CPU sequencer; CPU_CTRL_SKZ_EN enables conditional skip
module cpu_ctrl (
    input  logic         clk,
    input  logic         rst,
    cpu_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t     state, state_nxt;
    logic [4:0] pc, pc_nxt;
    logic [7:0] ir, ir_nxt;

    logic [2:0] op;
    logic [4:0] operand;
    logic       op_reads_mem;

    assign op           = ir[7:5];
    assign operand      = ir[4:0];
    assign op_reads_mem = (op == OP_ADD) || (op == OP_AND) ||
                          (op == OP_XOR) || (op == OP_LDA);

`ifndef CPU_CTRL_SKZ_EN
    logic skz_unused;
    assign skz_unused = bus.acc_zero;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            pc    <= 5'd0;
            ir    <= 8'h00;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ir_nxt       = ir;
        bus.mem_addr = pc;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.acc_load = 1'b0;
        bus.acc_sel  = 1'b0;
        bus.halt     = 1'b0;
        bus.alu_op   = op;

        case (state)
            S_FETCH: begin
                bus.mem_rd = 1'b1;
                state_nxt  = S_DECODE;
            end
            S_DECODE: begin
                ir_nxt    = bus.mem_rdata;
                pc_nxt    = pc + 5'd1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                bus.mem_addr = operand;
                state_nxt    = S_WB;
                case (op)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: bus.mem_rd = 1'b1;
                    OP_STO: bus.mem_wr = 1'b1;
                    OP_JMP: pc_nxt = operand;
                    OP_SKZ: begin
`ifdef CPU_CTRL_SKZ_EN
                        if (bus.acc_zero) begin
                            pc_nxt = pc + 5'd1;
                        end
`endif
                    end
                    OP_HLT: state_nxt = S_HALT;
                    default: state_nxt = S_WB;
                endcase
            end
            S_WB: begin
                bus.acc_load = op_reads_mem;
                bus.acc_sel  = (op == OP_LDA);
                state_nxt    = S_FETCH;
            end
            S_HALT: begin
                bus.halt = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        // Outputs follow reset combinationally so an in-flight write strobe drops at once.
        if (!rst) begin
            bus.mem_addr = 5'd0;
            bus.mem_rd   = 1'b0;
            bus.mem_wr   = 1'b0;
            bus.acc_load = 1'b0;
            bus.acc_sel  = 1'b0;
            bus.halt     = 1'b0;
            bus.alu_op   = 3'd0;
        end
    end
endmodule
